// File: rtl/tdm_demux.sv
// tdm_demux: receive side of a time-division-multiplexed link.
// One shared data line plus a frame-sync marker is split back into
// CHANNELS registered outputs. A two-state lock FSM (HUNT/LOCKED) and a
// round-robin slot counter track frame position; a sync marker seen away
// from slot 0 while locked raises sync_err and realigns to the new frame.
//
// Optional build macro TDM_DEMUX_FRAME_LATCH_EN: beats collect in shadow
// registers and the whole frame is released to dout together on the
// last-slot write. Without it every beat updates its own dout slice.
//
// Handshake: din is consumed on every rising edge where din_valid=1; there
// is no back-pressure. dout_valid[k] is a one-cycle strobe marking the cycle
// in which dout slice k was (re)written; slices otherwise hold their value.
module tdm_demux #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 2,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      din_valid,
  input  logic                      frame_sync,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       dout_valid,
  output logic                      frame_done,
  output logic [SEL_W-1:0]          slot,
  output logic                      locked,
  output logic                      sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Slot index of the last channel; the counter wraps here explicitly so
  // non-power-of-two channel counts never visit unused codes.
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(CHANNELS - 1);

  state_e                      state_q, state_d;
  logic [SEL_W-1:0]            slot_q, slot_d;
  logic [CHANNELS*WIDTH-1:0]   dout_q, dout_d;
  logic [CHANNELS-1:0]         dv_q, dv_d;
  logic                        fd_q, fd_d;
  logic                        se_q, se_d;

  // Beat-level write request decoded from the FSM.
  logic                        wr_en;
  logic [SEL_W-1:0]            wr_idx;

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
`endif

  // Lock FSM: decide whether this beat is written and into which slot.
  always_comb begin
    state_d = state_q;
    se_d    = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = '0;
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          // Only a sync beat can start a frame; anything else is dropped.
          if (frame_sync) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          wr_en = 1'b1;
          if (frame_sync && (slot_q != '0)) begin
            // Sync arrived early: abandon the partial frame, restart at 0.
            se_d   = 1'b1;
            wr_idx = '0;
          end else begin
            wr_idx = slot_q;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  // Datapath: advance the slot counter and route the beat to its channel.
  always_comb begin
    slot_d = slot_q;
    dout_d = dout_q;
    dv_d   = '0;
    fd_d   = 1'b0;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    shadow_d = shadow_q;
`endif
    if (wr_en) begin
      slot_d = (wr_idx == LAST_SLOT) ? '0 : wr_idx + SEL_W'(1);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_idx == SEL_W'(k)) begin
          shadow_d[k] = din;
        end
      end
      // Last slot completes the frame: publish every channel at once.
      // The last beat bypasses the shadow so it lands in the same cycle.
      if (wr_idx == LAST_SLOT) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (k == CHANNELS - 1) begin
            dout_d[k*WIDTH +: WIDTH] = din;
          end else begin
            dout_d[k*WIDTH +: WIDTH] = shadow_q[k];
          end
        end
        dv_d = '1;
        fd_d = 1'b1;
      end
`else
      for (int k = 0; k < CHANNELS; k++) begin
        if (wr_idx == SEL_W'(k)) begin
          dout_d[k*WIDTH +: WIDTH] = din;
          dv_d[k]                  = 1'b1;
        end
      end
      fd_d = (wr_idx == LAST_SLOT);
`endif
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      dout_q  <= '0;
      dv_q    <= '0;
      fd_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      fd_q    <= fd_d;
      se_q    <= se_d;
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  // Shadow frame buffer; stale entries are always overwritten before the
  // next publish because slots are written strictly in order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end
`endif

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign frame_done = fd_q;
  assign slot       = slot_q;
  assign locked     = (state_q == LOCKED);
  assign sync_err   = se_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Testbench for tdm_demux: a 2-channel 1-bit instance and a 4-channel
// 8-bit instance share clock and reset. A frame-level reference model
// (per-channel arrays, integer slot position) predicts every output.
module tb_tdm_demux;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       din2 = 1'b0;
  logic       v2   = 1'b0;
  logic       fs2  = 1'b0;
  logic [1:0] dout2;
  logic [1:0] dvo2;
  logic       fd2, se2, lk2;
  logic [0:0] slot2;

  logic [7:0]  din4 = 8'h00;
  logic        v4   = 1'b0;
  logic        fs4  = 1'b0;
  logic [31:0] dout4;
  logic [3:0]  dvo4;
  logic        fd4, se4, lk4;
  logic [1:0]  slot4;

  tdm_demux #(.WIDTH(1), .CHANNELS(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_valid(v2), .frame_sync(fs2),
    .dout(dout2), .dout_valid(dvo2), .frame_done(fd2), .slot(slot2),
    .locked(lk2), .sync_err(se2)
  );

  tdm_demux #(.WIDTH(8), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .frame_sync(fs4),
    .dout(dout4), .dout_valid(dvo4), .frame_done(fd4), .slot(slot4),
    .locked(lk4), .sync_err(se4)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic            locked;
    logic [31:0]     slot;
    logic [3:0][7:0] out;
    logic [3:0][7:0] sh;
  } mst_t;

  mst_t       m2, m4;
  logic [3:0] e2_dv, e4_dv;
  logic       e2_fd, e2_se, e4_fd, e4_se;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    m2 = '0; m4 = '0;
    e2_dv = '0; e4_dv = '0;
    e2_fd = 1'b0; e2_se = 1'b0; e4_fd = 1'b0; e4_se = 1'b0;
  endtask

  // One beat of the link as a frame-level view: where it lands, what is visible.
  task automatic model_beat(inout mst_t s, input int nch, input logic [7:0] d,
                            input logic v, input logic fs,
                            output logic [3:0] dv, output logic fd, output logic se);
    dv = '0; fd = 1'b0; se = 1'b0;
    if (!v) return;
    if (!s.locked) begin
      if (!fs) return;
      s.locked = 1'b1;
      s.slot   = 0;
    end else if (fs && s.slot != 0) begin
      se     = 1'b1;
      s.slot = 0;
      s.sh   = '0;
    end
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    s.sh[s.slot] = d;
    if (s.slot == nch - 1) begin
      for (int k = 0; k < nch; k++) s.out[k] = s.sh[k];
      dv = 4'((1 << nch) - 1);
      fd = 1'b1;
    end
`else
    s.out[s.slot] = d;
    dv[s.slot]    = 1'b1;
    fd            = (s.slot == nch - 1);
`endif
    s.slot = (s.slot + 1) % nch;
  endtask

  function automatic logic [7:0] obs2();
    return {dout2, dvo2, fd2, se2, slot2, lk2};
  endfunction
  function automatic logic [7:0] exp2();
    return {m2.out[1][0], m2.out[0][0], e2_dv[1:0], e2_fd, e2_se, m2.slot[0], m2.locked};
  endfunction
  function automatic logic [40:0] obs4();
    return {dout4, dvo4, fd4, se4, slot4, lk4};
  endfunction
  function automatic logic [40:0] exp4();
    return {m4.out, e4_dv, e4_fd, e4_se, m4.slot[1:0], m4.locked};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step2(input logic d, input logic v, input logic fs);
    @(negedge clk);
    din2 = d; v2 = v; fs2 = fs;
    model_beat(m2, 2, {7'b0, d}, v, fs, e2_dv, e2_fd, e2_se);
    @(posedge clk);
    #1;
    v2 = 1'b0; fs2 = 1'b0;
  endtask

  task automatic step4(input logic [7:0] d, input logic v, input logic fs);
    @(negedge clk);
    din4 = d; v4 = v; fs4 = fs;
    model_beat(m4, 4, d, v, fs, e4_dv, e4_fd, e4_se);
    @(posedge clk);
    #1;
    v4 = 1'b0; fs4 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL reset_async2: got=%h exp=%h", obs2(), exp2());
    end
    total++;
    if (obs4() !== exp4()) begin
      bad++; $display("FAIL reset_async4: got=%h exp=%h", obs4(), exp4());
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({dout4, dvo4, fd4, se4, slot4, lk4} !== 41'd0) begin
      bad++; $display("FAIL reset_held4: got=%h exp=0", obs4());
    end
  endtask

  task automatic test_hunt_discard();
    for (int i = 0; i < 2; i++) begin
      step2(1'b1, 1'b1, 1'b0);
      total++;
      if (obs2() !== exp2()) begin
        bad++; $display("FAIL hunt_discard beat%0d: got=%h exp=%h", i, obs2(), exp2());
      end
    end
    total++;
    if (lk2 !== 1'b0 || dout2 !== 2'b00 || dvo2 !== 2'b00) begin
      bad++; $display("FAIL hunt_outputs: got lk=%b dout=%b dv=%b exp 0/00/00", lk2, dout2, dvo2);
    end
  endtask

  task automatic test_basic_frame();
    step2(1'b1, 1'b1, 1'b1);
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL basic_sync: got=%h exp=%h", obs2(), exp2());
    end
    step2(1'b0, 1'b1, 1'b0);
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL basic_last: got=%h exp=%h", obs2(), exp2());
    end
    total++;
    if (fd2 !== 1'b1 || slot2 !== 1'b0 || dout2 !== 2'b01) begin
      bad++; $display("FAIL basic_done: got fd=%b slot=%b dout=%b exp 1/0/01", fd2, slot2, dout2);
    end
  endtask

  task automatic test_exhaustive_pairs();
    int fdc = 0;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] pr;
      pr = 2'(p);
      step2(pr[1], 1'b1, 1'b1);
      if (fd2 === 1'b1) fdc++;
      total++;
      if (obs2() !== exp2()) begin
        bad++; $display("FAIL pairs_ch0 p%0d: got=%h exp=%h", p, obs2(), exp2());
      end
      step2(pr[0], 1'b1, 1'b0);
      if (fd2 === 1'b1) fdc++;
      total++;
      if (dout2 !== {pr[0], pr[1]} || obs2() !== exp2()) begin
        bad++; $display("FAIL pairs_ch1 p%0d: got=%h exp=%h dout=%b", p, obs2(), exp2(), dout2);
      end
    end
    total++;
    if (fdc !== 4) begin
      bad++; $display("FAIL pairs_frame_done_count: got=%0d exp=4", fdc);
    end
  endtask

  task automatic test_gaps_async();
    step2(1'b1, 1'b1, 1'b1);
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL gaps_sync: got=%h exp=%h", obs2(), exp2());
    end
    for (int i = 0; i < 3; i++) begin
      step2(1'b0, 1'b0, 1'b0);
      total++;
      if (obs2() !== exp2()) begin
        bad++; $display("FAIL gaps_idle%0d: got=%h exp=%h", i, obs2(), exp2());
      end
    end
    step2(1'b1, 1'b1, 1'b0);
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL gaps_last: got=%h exp=%h", obs2(), exp2());
    end
    // Start another frame, then hit reset between edges.
    step2(1'b1, 1'b1, 1'b1);
    step4(8'h5A, 1'b1, 1'b1);
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (obs2() !== 8'd0 || obs4() !== 41'd0) begin
      bad++; $display("FAIL async_midframe: got2=%h got4=%h exp 0", obs2(), obs4());
    end
    @(negedge clk);
    rst = 1'b0;
    step2(1'b1, 1'b1, 1'b0);
    total++;
    if (obs2() !== exp2()) begin
      bad++; $display("FAIL post_reset_hunt: got=%h exp=%h", obs2(), exp2());
    end
  endtask

  task automatic test_misalign();
    logic [7:0] beats [3];
    logic       syncs [3];
    beats = '{8'hA1, 8'hB2, 8'hC3};
    syncs = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      step4(beats[i], 1'b1, syncs[i]);
      total++;
      if (obs4() !== exp4()) begin
        bad++; $display("FAIL misalign beat%0d: got=%h exp=%h", i, obs4(), exp4());
      end
    end
    total++;
    if (se4 !== 1'b1 || slot4 !== 2'd1 || fd4 !== 1'b0) begin
      bad++; $display("FAIL misalign_flags: got se=%b slot=%0d fd=%b exp 1/1/0", se4, slot4, fd4);
    end
  endtask

  task automatic test_frame_latch();
    logic [7:0] beats [4];
    beats = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      step4(beats[i], 1'b1, (i == 0));
      total++;
      if (obs4() !== exp4()) begin
        bad++; $display("FAIL frame beat%0d: got=%h exp=%h", i, obs4(), exp4());
      end
    end
    total++;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    if (dout4 !== 32'h44332211 || dvo4 !== 4'b1111 || fd4 !== 1'b1) begin
`else
    if (dout4 !== 32'h44332211 || dvo4 !== 4'b1000 || fd4 !== 1'b1) begin
`endif
      bad++; $display("FAIL frame_publish: got dout=%h dv=%b fd=%b", dout4, dvo4, fd4);
    end
    step4(8'h00, 1'b0, 1'b0);
    total++;
    if (dvo4 !== 4'b0000 || dout4 !== 32'h44332211) begin
      bad++; $display("FAIL frame_strobe_end: got dout=%h dv=%b exp 44332211/0000", dout4, dvo4);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] d;
      logic       v, fs;
      d  = 8'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      fs = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 1) == 0) begin
        step4(d, v, fs);
        total++;
        if (obs4() !== exp4()) begin
          bad++; $display("FAIL random4 step%0d: got=%h exp=%h", i, obs4(), exp4());
        end
      end else begin
        step2(d[0], v, fs);
        total++;
        if (obs2() !== exp2()) begin
          bad++; $display("FAIL random2 step%0d: got=%h exp=%h", i, obs2(), exp2());
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_hunt_discard();
    test_basic_frame();
    test_exhaustive_pairs();
    test_gaps_async();
    test_misalign();
    test_frame_latch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
